fifo_rd_packer: RTL and testbench

//  Read-side consumer of the async FIFO, in the rclk domain. Pops DSIZE-bit

---
 rtl/fifo_rd_packer.sv | 109 ++++++++++
 tb/tb_fifo_rd_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops RATIO show-ahead FIFO entries into one wide word
// and presents it on a valid/ready stream, with flush for partial words.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [DSIZE-1:0]       fifo_rdata,
  input  logic                   fifo_rempty,
  output logic                   fifo_rout,
  input  logic                   flush,
  output logic [DSIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int AW = DSIZE * (RATIO - 1);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0]          r_cnt;
  logic                   r_flush_pend;
  logic [AW-1:0]          r_acc;
  logic [DSIZE*RATIO-1:0] r_out_data;
  logic [RATIO-1:0]       r_out_keep;
  logic                   r_out_valid;

  logic                   w_ld;
  logic                   w_last;
  logic                   w_pop;
  logic                   w_emit;
  logic                   w_load;
  logic [AW-1:0]          w_part;
  logic [RATIO-1:0]       w_keep;

  assign w_ld   = !r_out_valid | out_ready;
  assign w_last = (r_cnt == LAST);
  assign w_pop  = rrst_n & !fifo_rempty & !r_flush_pend
                & (!w_last | w_ld);
  assign w_emit = r_flush_pend & (r_cnt != '0) & w_ld;
  assign w_load = (w_pop & w_last) | w_emit;

  // Lanes at or above cnt may hold stale bytes from an earlier word.
  always_comb begin
    w_part = '0;
    w_keep = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (CW'(i) < r_cnt) begin
        w_part[i*DSIZE +: DSIZE] = r_acc[i*DSIZE +: DSIZE];
        w_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_acc        <= '0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      if (r_flush_pend) begin
        if (r_cnt == '0) begin
          r_flush_pend <= 1'b0;
        end else if (w_ld) begin
          r_out_data   <= {{DSIZE{1'b0}}, w_part};
          r_out_keep   <= w_keep;
          r_out_valid  <= 1'b1;
          r_cnt        <= '0;
          r_flush_pend <= 1'b0;
        end
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_pop) begin
        if (w_last) begin
          r_out_data  <= {fifo_rdata, r_acc};
          r_out_keep  <= '1;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          for (int i = 0; i < RATIO - 1; i++) begin
            if (r_cnt == CW'(i)) begin
              r_acc[i*DSIZE +: DSIZE] <= fifo_rdata;
            end
          end
        end
      end

      if (!w_load && r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign fifo_rout = w_pop;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_valid = r_out_valid;
  assign busy      = r_flush_pend | (r_cnt != '0) | r_out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-modelled FIFO, byte-stream scoreboard
// and directed plus randomized steps.
module tb_fifo_rd_packer;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic [7:0]  fifo_rdata = '0;
  logic        fifo_rempty = 1'b1;
  logic        fifo_rout;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk(rclk), .rrst_n(rrst_n),
    .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_rout(fifo_rout), .flush(flush),
    .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 rclk = ~rclk;

  int n_chk = 0;
  int n_fail = 0;
  int n_pops = 0;

  logic [7:0]  q[$];
  logic [7:0]  acc[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_k[$];

  logic        s_valid, s_busy, s_rout;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        p_stall = 1'b0;
  logic [35:0] p_word = '0;

  task automatic chk(input string tag, input logic [35:0] obs,
                     input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void close_word();
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < acc.size(); i++) d[i*8 +: 8] = acc[i];
    exp_d.push_back(d);
    exp_k.push_back(4'((1 << acc.size()) - 1));
    acc.delete();
  endfunction

  task automatic cycle(input bit fl, input bit rdy, input bit gate);
    @(negedge rclk);
    flush       = fl;
    out_ready   = rdy;
    fifo_rempty = gate || (q.size() == 0);
    fifo_rdata  = (q.size() != 0) ? q[0] : 8'($urandom);
    #1;
    s_valid = out_valid;
    s_data  = out_data;
    s_keep  = out_keep;
    s_busy  = busy;
    s_rout  = fifo_rout;
    if (fifo_rout) chk("pop_while_empty", 36'(fifo_rempty), 36'(0));
    if (p_stall) chk("hold", {out_keep, out_data}, p_word);
    if (out_valid && out_ready) begin
      chk("word_expected", 36'(exp_d.size() != 0), 36'(1));
      if (exp_d.size() != 0) begin
        chk("word", {out_keep, out_data}, {exp_k[0], exp_d[0]});
        void'(exp_d.pop_front());
        void'(exp_k.pop_front());
      end
    end
    if (fifo_rout && !fifo_rempty) begin
      acc.push_back(q.pop_front());
      n_pops++;
      if (acc.size() == RATIO) close_word();
    end
    if (fl && acc.size() != 0) close_word();
    p_stall = out_valid && !out_ready;
    p_word  = {out_keep, out_data};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int p0;
    int t;

    // reset with a non-empty FIFO
    repeat (2) begin
      @(negedge rclk);
      fifo_rempty = 1'b0;
      fifo_rdata  = 8'h11;
      #1;
      chk("rst_rout", 36'(fifo_rout), 36'(0));
      chk("rst_valid", 36'(out_valid), 36'(0));
      chk("rst_busy", 36'(busy), 36'(0));
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    fifo_rempty = 1'b1;

    // full pack
    for (int i = 1; i <= 4; i++) q.push_back(8'(i));
    p0 = n_pops;
    repeat (4) cycle(0, 1, 0);
    chk("pack_pops", 36'(n_pops - p0), 36'(4));
    chk("pack_early", 36'(s_valid), 36'(0));
    cycle(0, 1, 0);
    chk("pack_valid", 36'(s_valid), 36'(1));
    chk("pack_data", 36'(s_data), 36'(32'h04030201));
    chk("pack_keep", 36'(s_keep), 36'(4'hF));
    cycle(0, 1, 0);
    chk("pack_1cyc", 36'(s_valid), 36'(0));

    // backpressure
    for (int i = 0; i < 12; i++) q.push_back(8'(i));
    repeat (10) cycle(0, 0, 0);
    chk("bp_left", 36'(q.size()), 36'(5));
    chk("bp_valid", 36'(s_valid), 36'(1));
    chk("bp_data", 36'(s_data), 36'(32'h03020100));
    chk("bp_stall", 36'(s_rout), 36'(0));
    repeat (12) cycle(0, 1, 0);
    chk("bp_words", 36'(exp_d.size()), 36'(0));
    chk("bp_fifo", 36'(q.size()), 36'(0));

    // flush partial
    q.push_back(8'hAA);
    q.push_back(8'hBB);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    chk("fp_pend_busy", 36'(s_busy), 36'(1));
    cycle(0, 1, 0);
    chk("fp_valid", 36'(s_valid), 36'(1));
    chk("fp_data", 36'(s_data), 36'(32'h0000BBAA));
    chk("fp_keep", 36'(s_keep), 36'(4'h3));
    cycle(0, 1, 0);
    chk("fp_idle", 36'(s_busy), 36'(0));

    // flush on empty
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    chk("fe_pend", 36'(s_busy), 36'(1));
    chk("fe_novalid", 36'(s_valid), 36'(0));
    cycle(0, 1, 0);
    chk("fe_clear", 36'(s_busy), 36'(0));
    chk("fe_novalid2", 36'(s_valid), 36'(0));

    // flush coincident with the last pop of a word
    for (int i = 0; i < 4; i++) q.push_back(8'(8'h50 + i));
    repeat (3) cycle(0, 1, 0);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    chk("fc_valid", 36'(s_valid), 36'(1));
    chk("fc_keep", 36'(s_keep), 36'(4'hF));
    cycle(0, 1, 0);
    chk("fc_noextra", 36'(s_valid), 36'(0));
    chk("fc_idle", 36'(s_busy), 36'(0));

    // randomized gaps, backpressure and flushes
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0 && q.size() < 16)
        q.push_back(8'($urandom));
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0);
    end

    t = 0;
    s_busy = 1'b1;
    while ((q.size() != 0 || exp_d.size() != 0 || acc.size() != 0 ||
            s_busy) && t < 300) begin
      cycle(acc.size() != 0 && q.size() == 0, 1, 0);
      t++;
    end
    chk("drain_timeout", 36'(t < 300), 36'(1));
    chk("drain_words", 36'(exp_d.size()), 36'(0));
    chk("drain_fifo", 36'(q.size()), 36'(0));
    chk("drain_busy", 36'(s_busy), 36'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
